token_stream_tx: RTL
====================

Name: token_stream_tx

Overview:
- Output-side reader for the embedding stage's token matrix.
- Samples the full N_TOK x D_MODEL Q4.4 token matrix on the embedder's one-cycle done pulse into a local buffer.
- Streams the buffer out one element per handshake, row-major, over a valid/ready interface to the downstream attention/encoder stage.
- Reports overrun when a new matrix arrives before the current one is fully drained.

Parameters:
N_TOK, 16, number of token rows (15 patch tokens + 1 class token)
D_MODEL, 16, elements per token row
DW, 8, element width, signed Q4.4

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
done_in  input  1  one-cycle pulse from the embedder: mat_in is valid this cycle
mat_in  input  DW x [N_TOK][D_MODEL]  signed token matrix, sampled only when done_in=1
m_valid  output  1  stream data valid
m_ready  input  1  downstream ready
m_data  output  DW  signed element buf[m_row][m_col]
m_row  output  $clog2(N_TOK)  row index of current element
m_col  output  $clog2(D_MODEL)  column index of current element
m_last_row  output  1  high when m_col = D_MODEL-1
m_last  output  1  high when m_row = N_TOK-1 and m_col = D_MODEL-1
busy  output  1  high while a matrix is held and not fully sent
drop_cnt  output  8  count of dropped done_in pulses, saturates at 255

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE; buffer cleared to 0.
  - m_valid=0, m_row=0, m_col=0, m_data=0, m_last_row=0, m_last=0, busy=0, drop_cnt=0.
  - Reset asserted mid-stream aborts the transfer. m_valid drops immediately. No partial resume after release.
- States: IDLE, SEND.
- IDLE:
  - m_valid=0.
  - done_in=1: buffer <= mat_in (all elements, one cycle); row/col <= 0; next state SEND.
- SEND:
  - m_valid=1; m_data=buf[row][col]; busy=1.
  - Handshake = m_valid & m_ready.
  - On handshake:
    - col < D_MODEL-1: col+1.
    - Otherwise col <= 0 and row+1.
  - Handshake on the last element (row=N_TOK-1, col=D_MODEL-1):
    - done_in=0 that cycle: go to IDLE.
    - done_in=1 that cycle: capture the new mat_in, reset row/col to 0, stay in SEND. This is a back-to-back matrix with no bubble; no drop is counted.
- done_in=1 in SEND in any other cycle:
  - Pulse ignored; buffer unchanged.
  - drop_cnt increments, saturating at 255.
- Latency: done_in at edge t -> m_valid=1 with element (0,0) after edge t.
- Stream rules:
  - While m_valid=1 and m_ready=0, m_data/m_row/m_col/m_last_row/m_last hold stable.
  - m_valid never deasserts inside a matrix except on reset.
- Throughput: with m_ready held 1, a matrix drains in N_TOK*D_MODEL = 256 consecutive cycles.
- m_last_row and m_last are decoded from the registered indices. They are meaningful only when m_valid=1 and forced 0 in IDLE.
- Data is passed unmodified: no arithmetic, no saturation, signed Q4.4 in = out.
- m_ready is ignored in IDLE.

Test Plan:
1. Reset, then done_in with mat_in[r][c]=r*16+c (8-bit wrap), m_ready=1 -> m_valid rises after the done edge. 256 beats with m_data = 0,1,...,255 as 8-bit. m_last_row on every 16th beat; m_last only on beat 256 (row 15, col 15). Then IDLE, m_valid=0.
2. Same matrix, m_ready toggling with a random 50% pattern -> identical 256-element sequence. Outputs stable across every stall cycle; no duplicated or skipped element.
3. Second done_in pulse (different matrix) at beat 100 -> stream continues the first matrix unchanged; drop_cnt=1. 300 extra pulses mid-stream -> drop_cnt saturates at 255.
4. done_in asserted in the same cycle as the final handshake, with matrix B = all 0x80 (-8.0) -> next beat is B[0][0]=0x80 with row/col 0. No IDLE cycle in between; drop_cnt unchanged.
5. rst_n pulled low at beat 37 -> m_valid=0 and busy=0 asynchronously; drop_cnt=0. After release, a fresh done_in restarts at (0,0).
6. Negative data: mat_in[15][*]=0xF0 (-1.0 class token) -> last 16 beats output 0xF0, sign preserved bit-exact.

Source files
------------

// File: rtl/token_stream_tx.sv
// token_stream_tx: captures the embedder's token matrix on done_in and streams it row-major over valid/ready.
module token_stream_tx #(
  parameter int N_TOK   = 16,
  parameter int D_MODEL = 16,
  parameter int DW      = 8,
  localparam int RW     = $clog2(N_TOK),
  localparam int CW     = $clog2(D_MODEL)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  done_in,
  input  logic [N_TOK-1:0][D_MODEL-1:0][DW-1:0] mat_in,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic signed [DW-1:0]                  m_data,
  output logic [RW-1:0]                         m_row,
  output logic [CW-1:0]                         m_col,
  output logic                                  m_last_row,
  output logic                                  m_last,
  output logic                                  busy,
  output logic [7:0]                            drop_cnt
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                                state_q, state_d;
  logic [RW-1:0]                         row_q, row_d;
  logic [CW-1:0]                         col_q, col_d;
  logic [N_TOK-1:0][D_MODEL-1:0][DW-1:0] buf_q, buf_d;
  logic [7:0]                            drop_q, drop_d;
  logic send, hs, end_col, end_mat;
  always_comb begin
    send    = state_q == SEND;
    hs      = send & m_ready;
    end_col = col_q == CW'(D_MODEL - 1);
    end_mat = end_col & (row_q == RW'(N_TOK - 1));
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    drop_d  = drop_q;
    if (!send) begin
      if (done_in) begin
        buf_d   = mat_in;
        row_d   = '0;
        col_d   = '0;
        state_d = SEND;
      end
    end else begin
      if (hs) begin
        col_d = end_col ? '0 : col_q + 1'b1;
        row_d = end_mat ? '0 : end_col ? row_q + 1'b1 : row_q;
        state_d = (end_mat & !done_in) ? IDLE : SEND;
        buf_d   = (end_mat & done_in) ? mat_in : buf_q;
      end
      // Only the pulse coinciding with the final handshake is accepted; any other one is dropped.
      if (done_in & !(hs & end_mat))
        drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      buf_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      drop_q  <= drop_d;
    end
  end
  assign m_valid    = send;
  assign busy       = send;
  assign m_row      = row_q;
  assign m_col      = col_q;
  assign m_data     = send ? buf_q[row_q][col_q] : '0;
  assign m_last_row = send & end_col;
  assign m_last     = send & end_mat;
  assign drop_cnt   = drop_q;
endmodule
